// File: rtl/ram1_shared_responder_pkg.sv
// Shared definitions for the parallel-core 1-bit RAM responder.
package ram1_shared_responder_pkg;

    localparam int unsigned DEFAULT_NUM_PORTS = 4;
    localparam int unsigned DEFAULT_ADDR_W    = 6;

    // SERVE arbitrates core accesses; CLEAR sweeps zeros through the whole array.
    typedef enum logic {
        StServe = 1'b0,
        StClear = 1'b1
    } state_e;

endpackage

// File: rtl/ram1_shared_responder_rr_arbiter.sv
// Combinational round-robin picker: one-hot selection of the first request at or after rr_ptr.
module rr_arbiter
    import ram1_shared_responder_pkg::*;
#(
    parameter int unsigned NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int unsigned PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [NUM_PORTS-1:0] sel
);

    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [2*NUM_PORTS-1:0] sel_dbl;
    logic [NUM_PORTS-1:0]   req_rot;
    logic [NUM_PORTS-1:0]   pick;
    logic                   found;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        req_dbl = {req, req} >> rr_ptr;
        req_rot = req_dbl[NUM_PORTS-1:0];
        pick    = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req_rot[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        sel_dbl = {pick, pick} << rr_ptr;
        sel     = sel_dbl[2*NUM_PORTS-1:NUM_PORTS];
    end

endmodule

// File: rtl/ram1_shared_responder.sv
// Single-port 1-bit RAM shared by several cores through a round-robin arbiter,
// with a full-array clear sweep after reset or on request.
module ram1_shared_responder
    import ram1_shared_responder_pkg::*;
#(
    parameter int unsigned NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int unsigned ADDR_W    = DEFAULT_ADDR_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS-1:0]        wdata,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic                        rdata,
    output logic                        busy
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_e                state_q;
    logic [PTR_W-1:0]      rr_ptr_q;
    logic [PTR_W-1:0]      rr_ptr_d;
    logic [ADDR_W-1:0]     clr_addr_q;
    logic [NUM_PORTS-1:0]  gnt_q;
    logic                  rdata_q;
    logic                  mem_q [DEPTH];

    logic [NUM_PORTS-1:0]  sel;
    logic                  sel_any;
    logic [ADDR_W-1:0]     sel_addr;
    logic                  sel_we;
    logic                  sel_wdata;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr_arbiter (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .sel    (sel)
    );

    // Steer the winning port's access fields and compute the pointer that follows it.
    always_comb begin
        sel_any   = |sel;
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = 1'b0;
        rr_ptr_d  = rr_ptr_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (sel[p]) begin
                sel_addr  = addr[p*ADDR_W +: ADDR_W];
                sel_we    = we[p];
                sel_wdata = wdata[p];
                rr_ptr_d  = PTR_W'((p + 1) % NUM_PORTS);
            end
        end
    end

    // Serve/clear FSM; grant, read data and memory all update on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            rdata_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StServe: begin
                    if (clear) begin
                        // Clear beats any pending request; requests stay pending.
                        state_q    <= StClear;
                        clr_addr_q <= '0;
                        gnt_q      <= '0;
                    end else begin
                        gnt_q <= sel;
                        if (sel_any) begin
                            rr_ptr_q <= rr_ptr_d;
                            if (sel_we) begin
                                mem_q[sel_addr] <= sel_wdata;
                            end else begin
                                rdata_q <= mem_q[sel_addr];
                            end
                        end
                    end
                end
                StClear: begin
                    gnt_q             <= '0;
                    mem_q[clr_addr_q] <= 1'b0;
                    clr_addr_q        <= clr_addr_q + 1'b1;
                    if (clr_addr_q == '1) begin
                        state_q <= StServe;
                    end
                end
                default: begin
                    state_q    <= StClear;
                    clr_addr_q <= '0;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign rdata = rdata_q;
    assign busy  = (state_q == StClear);

endmodule

// File: tb/tb_ram1_shared_responder.sv
// Self-checking bench for ram1_shared_responder: directed scenarios plus randomized traffic
// checked against a behavioural model of the shared 1-bit RAM.
module tb_ram1_shared_responder;

    localparam int NP    = 4;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic             clk;
    logic             reset;
    logic             clear;
    logic [NP-1:0]    req;
    logic [NP-1:0]    we;
    logic [NP*AW-1:0] addr;
    logic [NP-1:0]    wdata;
    logic [NP-1:0]    gnt;
    logic             rdata;
    logic             busy;

    int checks;
    int errors;

    // Behavioural model state
    bit          m_mem [DEPTH];
    int          m_ptr;
    int          m_sweep;      // clear-sweep cycles still to run
    logic [NP-1:0] exp_gnt;
    logic        exp_rdata;
    logic        exp_busy;

    ram1_shared_responder #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .gnt   (gnt),
        .rdata (rdata),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge worth of the memory's documented behaviour.
    task automatic model_step();
        int p;
        int a;
        bit found;
        if (reset) begin
            m_sweep   = DEPTH;
            m_ptr     = 0;
            exp_gnt   = '0;
            exp_rdata = 1'b0;
            exp_busy  = 1'b1;
        end else if (m_sweep > 0) begin
            m_mem[DEPTH - m_sweep] = 1'b0;
            m_sweep  = m_sweep - 1;
            exp_gnt  = '0;
            exp_busy = (m_sweep > 0);
        end else if (clear) begin
            m_sweep  = DEPTH;
            exp_gnt  = '0;
            exp_busy = 1'b1;
        end else begin
            found    = 1'b0;
            exp_gnt  = '0;
            exp_busy = 1'b0;
            for (int k = 0; k < NP; k++) begin
                p = (m_ptr + k) % NP;
                if (!found && req[p]) begin
                    found      = 1'b1;
                    exp_gnt[p] = 1'b1;
                    a = int'(addr[p*AW +: AW]);
                    if (we[p]) m_mem[a] = wdata[p];
                    else       exp_rdata = m_mem[a];
                    m_ptr = (p + 1) % NP;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_port(input int p, input bit w, input int a, input bit d);
        req[p]           = 1'b1;
        we[p]            = w;
        addr[p*AW +: AW] = AW'(a);
        wdata[p]         = d;
    endtask

    // Single-port access held for exactly one edge.
    task automatic access(input int p, input bit w, input int a, input bit d);
        set_port(p, w, a, d);
        tick();
        req[p] = 1'b0;
    endtask

    // Counts busy cycles from the current one until busy drops (bounded).
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || rdata !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: gnt=%b rdata=%b busy=%b, required gnt=0000 rdata=0 busy=1",
                     gnt, rdata, busy);
        end
        wait_idle(n);
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL reset_sweep_len: busy cycles=%0d, required 64", n);
        end
        // Dirty both ends of the array, then confirm a second reset sweeps them away.
        access(1, 1'b1, 0, 1'b1);
        access(2, 1'b1, 63, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_idle(n);
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL reset2_sweep_len: busy cycles=%0d, required 64", n);
        end
        access(0, 1'b0, 0, 1'b0);
        checks++;
        if (gnt !== 4'b0001 || rdata !== 1'b0) begin
            errors++;
            $display("FAIL load_addr0: gnt=%b rdata=%b, required gnt=0001 rdata=0", gnt, rdata);
        end
        access(3, 1'b0, 63, 1'b0);
        checks++;
        if (gnt !== 4'b1000 || rdata !== 1'b0) begin
            errors++;
            $display("FAIL load_addr63: gnt=%b rdata=%b, required gnt=1000 rdata=0", gnt, rdata);
        end
    endtask

    task automatic test_store_load();
        access(2, 1'b1, 5, 1'b1);
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL store_p2_gnt: gnt=%b, required 0100", gnt);
        end
        access(0, 1'b0, 5, 1'b0);
        checks++;
        if (gnt !== 4'b0001 || rdata !== 1'b1) begin
            errors++;
            $display("FAIL load_p0_addr5: gnt=%b rdata=%b, required gnt=0001 rdata=1", gnt, rdata);
        end
        tick();
        checks++;
        if (gnt !== 4'b0000 || rdata !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold: gnt=%b rdata=%b, required gnt=0000 rdata=1", gnt, rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] order [5];
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b0100;
        order[3] = 4'b1000;
        order[4] = 4'b0001;
        access(3, 1'b0, 0, 1'b0);   // leaves the pointer at 0
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, p + 4, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (gnt !== order[k] || rdata !== exp_rdata) begin
                errors++;
                $display("FAIL rr_grant_%0d: gnt=%b rdata=%b, required gnt=%b rdata=%b",
                         k, gnt, rdata, order[k], exp_rdata);
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_same_addr();
        access(1, 1'b0, 0, 1'b0);   // leaves the pointer at 2
        set_port(1, 1'b1, 9, 1'b1);
        set_port(3, 1'b1, 9, 1'b0);
        tick();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL collide_first: gnt=%b, required 1000", gnt);
        end
        req[3] = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL collide_second: gnt=%b, required 0010", gnt);
        end
        req[1] = 1'b0;
        access(0, 1'b0, 9, 1'b0);
        checks++;
        if (rdata !== 1'b1) begin
            errors++;
            $display("FAIL collide_final: rdata=%b, required 1", rdata);
        end
    endtask

    task automatic test_clear();
        int n;
        bit gnt_seen;
        clear = 1'b1;
        set_port(0, 1'b0, 9, 1'b0);
        tick();
        clear = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_wins: gnt=%b busy=%b, required gnt=0000 busy=1", gnt, busy);
        end
        n = 0;
        gnt_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            n++;
            clear = (n == 10);      // a second pulse mid-sweep must not restart it
            tick();
            if (gnt !== '0) gnt_seen = 1'b1;
        end
        clear = 1'b0;
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL clear_sweep_len: busy cycles=%0d, required 64", n);
        end
        checks++;
        if (gnt_seen !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_gnt: grant seen=%b, required 0", gnt_seen);
        end
        tick();
        req[0] = 1'b0;
        checks++;
        if (gnt !== 4'b0001 || rdata !== 1'b0) begin
            errors++;
            $display("FAIL post_clear_gnt: gnt=%b rdata=%b, required gnt=0001 rdata=0", gnt, rdata);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        access(2, 1'b1, 40, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_busy: busy=%b, required 1", busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_idle(n);
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL restart_sweep_len: busy cycles=%0d, required 64", n);
        end
        access(0, 1'b0, 40, 1'b0);
        checks++;
        if (gnt !== 4'b0001 || rdata !== 1'b0) begin
            errors++;
            $display("FAIL restart_cleared: gnt=%b rdata=%b, required gnt=0001 rdata=0", gnt, rdata);
        end
    endtask

    task automatic test_random();
        int n;
        int bad;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            req   = NP'($urandom_range(0, 15));
            we    = NP'($urandom_range(0, 15));
            wdata = NP'($urandom_range(0, 15));
            for (int p = 0; p < NP; p++) addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            clear = ($urandom_range(0, 79) == 0);
            tick();
            checks++;
            if (gnt !== exp_gnt || rdata !== exp_rdata || busy !== exp_busy) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_%0d: gnt=%b rdata=%b busy=%b, required gnt=%b rdata=%b busy=%b",
                             c, gnt, rdata, busy, exp_gnt, exp_rdata, exp_busy);
                bad++;
            end
        end
        req   = '0;
        clear = 1'b0;
        wait_idle(n);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        m_ptr     = 0;
        m_sweep   = 0;
        exp_gnt   = '0;
        exp_rdata = 1'b0;
        exp_busy  = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 1'b0;
        reset = 1'b0;
        clear = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        #2;
        test_reset();
        test_store_load();
        test_round_robin();
        test_same_addr();
        test_clear();
        test_reset_mid_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
